// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared encodings for the PC flow controller.
package pc_ctrl_pkg;
  typedef enum logic [1:0] {SEQ, TARGET, EXC_VEC, EPC} npc_sel_t;
  typedef enum logic [1:0] {RUN, BR, CP0, CP0_LD} state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in EX is still fetching.
module load_use_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rt_i,
  output logic       lu_o
);
  assign lu_o = ex_mem_read_i && |ex_rt_i && (ex_rt_i == id_rs_i || (id_use_rt_i && ex_rt_i == id_rt_i));
endmodule

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: load-use stalls, branch redirect and CP0 redirect sequencing for PC and IF/ID, ID/EX.
module pc_flow_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int CP0_BUBBLES = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_useRt,
  input  logic [4:0] EX_rt,
  input  logic       EX_MemRead,
  input  logic       ID_BranchTaken,
  input  logic       ID_Jump,
  input  logic       cp0Exception,
  input  logic       cp0Eret,
  output logic       hazard,
  output logic       BranchBubble,
  output logic       cp0Bubble,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic [1:0] NPCSel
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic kind_q, kind_d;
  logic lu, cp0_ev;
  npc_sel_t npc;
  load_use_detect u_lu (
    .ex_mem_read_i(EX_MemRead),
    .ex_rt_i(EX_rt),
    .id_rs_i(ID_rs),
    .id_rt_i(ID_rt),
    .id_use_rt_i(ID_useRt),
    .lu_o(lu)
  );
  // CP0 requests are only accepted outside an ongoing CP0 sequence
  assign cp0_ev = (cp0Exception || cp0Eret) && (state_q == RUN || state_q == BR);
  assign NPCSel = npc;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    kind_d = kind_q;
    hazard = 1'b0;
    BranchBubble = 1'b0;
    cp0Bubble = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    npc = SEQ;
    if (cp0_ev) begin
      kind_d = cp0Exception;
      cnt_d = CNT_W'(CP0_BUBBLES - 1);
      state_d = CP0;
      cp0Bubble = 1'b1;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (lu) begin
            hazard = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (ID_BranchTaken || ID_Jump) begin
            BranchBubble = 1'b1;
            IFID_Flush = 1'b1;
            state_d = BR;
          end
        end
        BR: begin
          npc = TARGET;
          state_d = RUN;
        end
        CP0: begin
          cp0Bubble = 1'b1;
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
          if (cnt_q == '0) state_d = CP0_LD;
          else cnt_d = cnt_q - 1'b1;
        end
        CP0_LD: begin
          npc = kind_q ? EXC_VEC : EPC;
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      kind_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      kind_q <= kind_d;
    end
  end
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb_pc_flow_ctrl: directed and randomized checks against a redirect-timeline model of the controller.
module tb_pc_flow_ctrl;
  localparam int B = 3;
  logic Clk = 1'b0, Reset = 1'b0;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
  logic ID_useRt = 1'b0, EX_MemRead = 1'b0, ID_BranchTaken = 1'b0, ID_Jump = 1'b0;
  logic cp0Exception = 1'b0, cp0Eret = 1'b0;
  logic hazard, BranchBubble, cp0Bubble, IFID_Flush, IDEX_Flush;
  logic [1:0] NPCSel;
  int n_chk = 0, n_pass = 0;
  int c = 0, cp0_start = -1, cp0_end = -1, br_at = -1;
  bit kind = 0;
  always #5 Clk = ~Clk;
  pc_flow_ctrl #(.CP0_BUBBLES(B)) dut (
    .Clk(Clk), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_useRt(ID_useRt),
    .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .cp0Exception(cp0Exception), .cp0Eret(cp0Eret), .hazard(hazard), .BranchBubble(BranchBubble),
    .cp0Bubble(cp0Bubble), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .NPCSel(NPCSel)
  );
  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
  endtask
  task automatic model_clear();
    cp0_start = -1;
    cp0_end = -1;
    br_at = -1;
    kind = 0;
  endtask
  // The model tracks future redirect cycles: a CP0 window (bubbles then a vector load) and a branch target cycle.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic [4:0] ert,
                      input logic mr, input logic bt, input logic jmp, input logic exc, input logic eret);
    bit in_win, lu_m;
    logic e_h, e_bb, e_cb, e_if, e_ie;
    logic [1:0] e_npc;
    @(negedge Clk);
    ID_rs = rs; ID_rt = rt; ID_useRt = urt; EX_rt = ert; EX_MemRead = mr;
    ID_BranchTaken = bt; ID_Jump = jmp; cp0Exception = exc; cp0Eret = eret;
    #1;
    {e_h, e_bb, e_cb, e_if, e_ie} = '0;
    e_npc = 2'd0;
    in_win = cp0_end >= 0 && c > cp0_start && c <= cp0_end;
    lu_m = mr && ert != 0 && (ert == rs || (urt && ert == rt));
    if (in_win) begin
      e_if = 1; e_ie = 1;
      if (c < cp0_end) e_cb = 1;
      else e_npc = kind ? 2'd2 : 2'd3;
    end else if (exc || eret) begin
      e_cb = 1; e_if = 1; e_ie = 1;
      cp0_start = c; cp0_end = c + B + 1; kind = exc; br_at = -1;
    end else if (br_at == c) e_npc = 2'd1;
    else if (lu_m) begin
      e_h = 1; e_ie = 1;
    end else if (bt || jmp) begin
      e_bb = 1; e_if = 1; br_at = c + 1;
    end
    chk("hazard", {1'b0, hazard}, {1'b0, e_h});
    chk("BranchBubble", {1'b0, BranchBubble}, {1'b0, e_bb});
    chk("cp0Bubble", {1'b0, cp0Bubble}, {1'b0, e_cb});
    chk("IFID_Flush", {1'b0, IFID_Flush}, {1'b0, e_if});
    chk("IDEX_Flush", {1'b0, IDEX_Flush}, {1'b0, e_ie});
    chk("NPCSel", NPCSel, e_npc);
    c++;
  endtask
  task automatic quiet();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    Reset = 1'b0;
    {ID_rs, ID_rt, EX_rt} = '0;
    {ID_useRt, EX_MemRead, ID_BranchTaken, ID_Jump, cp0Exception, cp0Eret} = '0;
    #1;
    chk("rst_outs", {1'b0, hazard | BranchBubble | cp0Bubble | IFID_Flush | IDEX_Flush}, 2'd0);
    chk("rst_npc", NPCSel, 2'd0);
    @(negedge Clk);
    Reset = 1'b1;
    model_clear();
  endtask
  initial begin
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    quiet();
    chk("lit_rst_cb", {1'b0, cp0Bubble}, 2'd0);
    chk("lit_rst_npc", NPCSel, 2'd0);
    // load-use cases
    step(5, 0, 0, 5, 1, 0, 0, 0, 0);
    chk("lit_lu_h", {1'b0, hazard}, 2'd1);
    chk("lit_lu_ie", {1'b0, IDEX_Flush}, 2'd1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("lit_lu_rt0", {1'b0, hazard}, 2'd0);
    step(1, 5, 0, 5, 1, 0, 0, 0, 0);
    chk("lit_lu_norurt", {1'b0, hazard}, 2'd0);
    step(1, 5, 1, 5, 1, 0, 0, 0, 0);
    chk("lit_lu_rt", {1'b0, hazard}, 2'd1);
    // branch redirect
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("lit_br_bb", {1'b0, BranchBubble & IFID_Flush}, 2'd1);
    quiet();
    chk("lit_br_npc1", NPCSel, 2'd1);
    quiet();
    chk("lit_br_npc0", NPCSel, 2'd0);
    // exception and eret sequences
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("lit_exc_cb0", {1'b0, cp0Bubble}, 2'd1);
    repeat (3) quiet();
    chk("lit_exc_cb3", {1'b0, cp0Bubble}, 2'd1);
    quiet();
    chk("lit_exc_npc", NPCSel, 2'd2);
    quiet();
    chk("lit_exc_run", {NPCSel[1], cp0Bubble}, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) quiet();
    chk("lit_eret_npc", NPCSel, 2'd3);
    // lu and jump together, then jump alone
    step(7, 0, 0, 7, 1, 0, 1, 0, 0);
    chk("lit_luj_h", {hazard, BranchBubble}, 2'b10);
    step(7, 0, 0, 7, 0, 0, 1, 0, 0);
    chk("lit_luj_bb", {1'b0, BranchBubble}, 2'd1);
    quiet();
    // eret in the BR cycle, later exception ignored
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit_brcp0_npc", NPCSel, 2'd0);
    quiet();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    quiet();
    quiet();
    chk("lit_brcp0_vec", NPCSel, 2'd3);
    quiet();
    // reset aborts CP0 at cnt=1
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    quiet();
    quiet();
    do_reset();
    quiet();
    chk("lit_postrst", {1'b0, cp0Bubble | IFID_Flush}, 2'd0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
